// File: rtl/linear_row_scheduler.sv
// ---------------------------------------------------------------------------
// linear_row_scheduler
//
// Drives the pipelined 32-input float linear unit across the rows of a weight
// matrix to build one RNN layer output vector. Rows are issued one per
// accepted handshake with a cap on rows in flight. Results come back in order
// and are written to the output buffer. An abort stops issuing and drains
// whatever is still in the pipe without writing it.
//
// Ports:
//   clk, rst_n           clock; asynchronous active-low reset
//   start, n_rows        begin a layer of n_rows rows (sampled only when idle)
//   abort                stop issuing and flush in-flight results
//   busy                 high whenever the scheduler is not idle
//   done                 one-cycle pulse on normal completion
//   aborted              one-cycle pulse when an abort flush completes
//   err_unexpected       sticky: a result arrived with nothing in flight
//   lin_valid/lin_ready  row request handshake to the linear unit
//   row_idx              row being requested (selects vector/weights/bias)
//   lin_done/lin_result  in-order single-cycle result from the linear unit
//   out_we/out_addr/out_data  output buffer write port
// ---------------------------------------------------------------------------
module linear_row_scheduler #(
    parameter int N_OUT        = 32,
    parameter int MAX_INFLIGHT = 8,
    parameter int ROW_W        = $clog2(N_OUT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ROW_W-1:0] n_rows,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err_unexpected,
    output logic             lin_valid,
    input  logic             lin_ready,
    output logic [ROW_W-1:0] row_idx,
    input  logic             lin_done,
    input  logic [31:0]      lin_result,
    output logic             out_we,
    output logic [ROW_W-1:0] out_addr,
    output logic [31:0]      out_data
);

    localparam int IF_W = $clog2(MAX_INFLIGHT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    localparam logic [ROW_W-1:0] N_OUT_C  = ROW_W'(N_OUT);
    localparam logic [IF_W-1:0]  MAX_IF_C = IF_W'(MAX_INFLIGHT);

    logic [1:0]       state_reg,     state_next;
    logic [ROW_W-1:0] n_lat_reg,     n_lat_next;
    logic [ROW_W-1:0] issue_cnt_reg, issue_cnt_next;
    logic [ROW_W-1:0] ret_cnt_reg,   ret_cnt_next;
    logic [IF_W-1:0]  inflight_reg,  inflight_next;
    logic             err_reg,       err_next;
    logic             done_reg,      done_next;
    logic             aborted_reg,   aborted_next;
    logic             out_we_reg,    out_we_next;
    logic [ROW_W-1:0] out_addr_reg,  out_addr_next;
    logic [31:0]      out_data_reg,  out_data_next;

    logic             can_issue;
    logic             fire;
    logic             ret_ok;
    logic             spurious;
    logic [ROW_W-1:0] issue_inc;
    logic [ROW_W-1:0] ret_inc;

    // abort is folded in so a request is never presented in the cycle the
    // scheduler decides to stop; lin_ready is deliberately not used here.
    assign can_issue = (state_reg == S_ISSUE) && (issue_cnt_reg < n_lat_reg) &&
                       (inflight_reg < MAX_IF_C) && !abort;
    assign fire      = can_issue && lin_ready;
    assign ret_ok    = lin_done && (inflight_reg != '0);
    assign spurious  = lin_done && (inflight_reg == '0);
    assign issue_inc = issue_cnt_reg + 1'b1;
    assign ret_inc   = ret_cnt_reg + 1'b1;

    always_comb begin
        state_next     = state_reg;
        n_lat_next     = n_lat_reg;
        issue_cnt_next = issue_cnt_reg;
        ret_cnt_next   = ret_cnt_reg;
        inflight_next  = inflight_reg;
        err_next       = err_reg | spurious;
        done_next      = 1'b0;
        aborted_next   = 1'b0;
        out_we_next    = 1'b0;
        out_addr_next  = out_addr_reg;
        out_data_next  = out_data_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (n_rows == '0) begin
                        done_next = 1'b1;
                    end else begin
                        n_lat_next     = (n_rows > N_OUT_C) ? N_OUT_C : n_rows;
                        issue_cnt_next = '0;
                        ret_cnt_next   = '0;
                        // a stray result in the very start cycle still counts
                        err_next       = spurious;
                        state_next     = S_ISSUE;
                    end
                end
            end

            S_ISSUE, S_DRAIN: begin
                if (abort) begin
                    // a result landing in the abort cycle is discarded like
                    // every other result that arrives during the flush
                    state_next = S_FLUSH;
                    if (ret_ok) begin
                        inflight_next = inflight_reg - 1'b1;
                    end
                end else begin
                    if (fire) begin
                        issue_cnt_next = issue_inc;
                        if (issue_inc == n_lat_reg) begin
                            state_next = S_DRAIN;
                        end
                    end
                    if (ret_ok) begin
                        out_we_next   = 1'b1;
                        out_addr_next = ret_cnt_reg;
                        out_data_next = lin_result;
                        ret_cnt_next  = ret_inc;
                        if ((state_reg == S_DRAIN) && (ret_inc == n_lat_reg)) begin
                            done_next  = 1'b1;
                            state_next = S_IDLE;
                        end
                    end
                    if (fire && !ret_ok) begin
                        inflight_next = inflight_reg + 1'b1;
                    end else if (!fire && ret_ok) begin
                        inflight_next = inflight_reg - 1'b1;
                    end
                end
            end

            S_FLUSH: begin
                if (ret_ok) begin
                    inflight_next = inflight_reg - 1'b1;
                end
                if (inflight_next == '0) begin
                    aborted_next = 1'b1;
                    state_next   = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            n_lat_reg     <= '0;
            issue_cnt_reg <= '0;
            ret_cnt_reg   <= '0;
            inflight_reg  <= '0;
            err_reg       <= 1'b0;
            done_reg      <= 1'b0;
            aborted_reg   <= 1'b0;
            out_we_reg    <= 1'b0;
            out_addr_reg  <= '0;
            out_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            n_lat_reg     <= n_lat_next;
            issue_cnt_reg <= issue_cnt_next;
            ret_cnt_reg   <= ret_cnt_next;
            inflight_reg  <= inflight_next;
            err_reg       <= err_next;
            done_reg      <= done_next;
            aborted_reg   <= aborted_next;
            out_we_reg    <= out_we_next;
            out_addr_reg  <= out_addr_next;
            out_data_reg  <= out_data_next;
        end
    end

    assign busy           = (state_reg != S_IDLE);
    assign done           = done_reg;
    assign aborted        = aborted_reg;
    assign err_unexpected = err_reg;
    assign lin_valid      = can_issue;
    assign row_idx        = issue_cnt_reg;
    assign out_we         = out_we_reg;
    assign out_addr       = out_addr_reg;
    assign out_data       = out_data_reg;

endmodule
